// File: rtl/fifo_tx_serializer.sv
// Drains a sync FIFO one word at a time and shifts each word out on a
// 3-wire SPI-style link (cs_n/sclk/sdo), mode 0.
// Optional feature: define FIFO_SER_PARITY_EN to append one parity bit per word.
module fifo_tx_serializer #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ser_en_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             msb_first_i,
  input  logic             parity_odd_i,
  input  logic             fifo_empty_i,
  input  logic [DW-1:0]    fifo_rd_data_i,
  output logic             fifo_rd_en_o,
  output logic             cs_n_o,
  output logic             sclk_o,
  output logic             sdo_o,
  output logic             busy_o,
  output logic             word_done_o,
  output logic [15:0]      word_cnt_o
);

`ifdef FIFO_SER_PARITY_EN
  localparam int unsigned NBITS = DW + 1;
`else
  localparam int unsigned NBITS = DW;
`endif
  localparam int unsigned CntW = $clog2(NBITS);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q;
  logic [DW-1:0]    sreg_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_q;
  logic             msb_q;
  logic             cs_n_q;
  logic             sclk_q;
  logic             sdo_q;
  logic             word_done_q;
  logic [15:0]      word_cnt_q;

  logic [DW-1:0]    sreg_d;
  logic             next_bit_d;
  logic             first_bit_d;
  logic             div_tc;
  logic             last_bit;

`ifdef FIFO_SER_PARITY_EN
  logic             parity_q;
`else
  logic             unused_parity_odd;
  assign unused_parity_odd = parity_odd_i;
`endif

  // Pop only from IDLE and only when the FIFO holds data, so read errors cannot occur.
  assign fifo_rd_en_o = (state_q == StIdle) & ser_en_i & ~fifo_empty_i;
  assign busy_o       = (state_q != StIdle);
  assign cs_n_o       = cs_n_q;
  assign sclk_o       = sclk_q;
  assign sdo_o        = sdo_q;
  assign word_done_o  = word_done_q;
  assign word_cnt_o   = word_cnt_q;

  // Shift-register next value and the bit that follows the current one on the wire.
  always_comb begin
    div_tc      = (div_cnt_q == div_q);
    last_bit    = (bit_cnt_q == CntW'(NBITS - 1));
    first_bit_d = msb_first_i ? fifo_rd_data_i[DW-1] : fifo_rd_data_i[0];
    sreg_d      = msb_q ? {sreg_q[DW-2:0], 1'b0} : {1'b0, sreg_q[DW-1:1]};
    next_bit_d  = msb_q ? sreg_q[DW-2] : sreg_q[1];
`ifdef FIFO_SER_PARITY_EN
    // After the last data bit the parity bit goes out.
    if (bit_cnt_q == CntW'(DW - 1)) next_bit_d = parity_q;
`endif
  end

  // Frame FSM with registered link outputs; ser_en low aborts to idle from any state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      div_q       <= '0;
      msb_q       <= 1'b1;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      sdo_q       <= 1'b0;
      word_done_q <= 1'b0;
      word_cnt_q  <= '0;
`ifdef FIFO_SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (!ser_en_i) begin
      // In-flight word is dropped; word_cnt_q is intentionally held.
      state_q     <= StIdle;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      sdo_q       <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      word_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty_i) begin
            state_q   <= StShift;
            sreg_q    <= fifo_rd_data_i;
            div_q     <= clk_div_i;
            msb_q     <= msb_first_i;
            cs_n_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdo_q     <= first_bit_d;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
`ifdef FIFO_SER_PARITY_EN
            parity_q  <= (^fifo_rd_data_i) ^ parity_odd_i;
`endif
          end
        end
        StShift: begin
          if (div_tc) begin
            div_cnt_q <= '0;
            sclk_q    <= ~sclk_q;
            if (sclk_q) begin
              if (last_bit) begin
                state_q     <= StGap;
                cs_n_q      <= 1'b1;
                sdo_q       <= 1'b0;
                word_done_q <= 1'b1;
                word_cnt_q  <= word_cnt_q + 16'd1;
              end else begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
                sdo_q     <= next_bit_d;
                sreg_q    <= sreg_d;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        StGap: begin
          if (div_tc) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Self-checking bench for fifo_tx_serializer: behavioural FIFO, link monitor and
// a frame-level reference model (expected bit sequence, cs_n width, capture spacing).
module tb_fifo_tx_serializer;

`ifdef FIFO_SER_PARITY_EN
  localparam int NBITS = 17;
`else
  localparam int NBITS = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ser_en = 1'b0;
  logic [7:0]  clk_div = 8'd0;
  logic        msb_first = 1'b1;
  logic        parity_odd = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_rd_data = 16'h0;
  logic        fifo_rd_en, cs_n, sclk, sdo, busy, word_done;
  logic [15:0] word_cnt;

  fifo_tx_serializer #(.DW(16), .DIV_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ser_en_i(ser_en), .clk_div_i(clk_div),
    .msb_first_i(msb_first), .parity_odd_i(parity_odd), .fifo_empty_i(fifo_empty),
    .fifo_rd_data_i(fifo_rd_data), .fifo_rd_en_o(fifo_rd_en), .cs_n_o(cs_n),
    .sclk_o(sclk), .sdo_o(sdo), .busy_o(busy), .word_done_o(word_done),
    .word_cnt_o(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bits;
    int          n;
    int          low;
  } frame_t;

  frame_t      got_q[$];
  frame_t      exp_q[$];
  logic [15:0] fifo_q[$];
  int          cap_q[$];
  int          cyc = 0;
  int          wd_cnt = 0;
  int          bad_rd = 0;
  logic [31:0] mon_bits = 0;
  int          mon_n = 0;
  int          mon_low = 0;
  logic        sclk_prev = 1'b0;
  logic        cs_prev = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;

  // Expected on-wire order: word in the chosen bit order, then parity if enabled.
  function automatic logic [31:0] exp_seq(logic [15:0] w, logic msb, logic podd);
    logic [31:0] s = 32'h0;
    for (int i = 0; i < 16; i++) s = {s[30:0], msb ? w[15-i] : w[i]};
`ifdef FIFO_SER_PARITY_EN
    s = {s[30:0], (^w) ^ podd};
`else
    if (podd) s = s;
`endif
    return s;
  endfunction

  // Behavioural FIFO; the model frame is recorded with the config seen at the pop edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && fifo_q.size() > 0) begin
      exp_q.push_back(frame_t'{bits: exp_seq(fifo_q[0], msb_first, parity_odd), n: NBITS,
                               low: NBITS * 2 * (int'(clk_div) + 1)});
      cap_q.push_back(cyc);
      void'(fifo_q.pop_front());
    end
    fifo_empty   <= (fifo_q.size() == 0);
    fifo_rd_data <= (fifo_q.size() > 0) ? fifo_q[0] : 16'h0;
  end

  // Link monitor: bits on sclk rising while cs_n low; a frame closes when cs_n rises.
  always @(negedge clk) begin
    sclk_prev <= sclk;
    cs_prev   <= cs_n;
    if (word_done) wd_cnt <= wd_cnt + 1;
    if (fifo_rd_en && (fifo_empty || busy)) bad_rd <= bad_rd + 1;
    if (!cs_n) begin
      mon_low <= mon_low + 1;
      if (sclk && !sclk_prev) begin
        mon_bits <= {mon_bits[30:0], sdo};
        mon_n    <= mon_n + 1;
      end
    end
    if (cs_n && !cs_prev) begin
      got_q.push_back(frame_t'{bits: mon_bits, n: mon_n, low: mon_low});
      mon_bits <= 0;
      mon_n    <= 0;
      mon_low  <= 0;
    end
  end

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int idle_bad = 0;
    rst_ni = 1'b0;
    ser_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs_n, sclk, sdo, busy, word_done, fifo_rd_en, word_cnt} !== {6'b100000, 16'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got %b_%h expected 100000_0000",
               {cs_n, sclk, sdo, busy, word_done, fifo_rd_en}, word_cnt);
    end
    rst_ni = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en || !cs_n || busy) idle_bad++;
    end
    checks++;
    if (idle_bad != 0) begin
      errors++;
      $display("FAIL empty_idle: got %0d active cycles expected 0", idle_bad);
    end
  endtask

  task automatic test_msb();
    frame_t f, e;
    bit ok;
    int base = wd_cnt;
    msb_first = 1'b1;
    clk_div = 8'd0;
    fifo_q.push_back(16'hA5C3);
    wait_frames(1, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL msb_timeout: got no frame expected 1 frame");
    end else begin
      f = got_q.pop_front();
      e = exp_q.pop_front();
      exp_cnt++;
      checks++;
      if ((f.bits >> (NBITS - 16)) !== 32'h0000A5C3) begin
        errors++;
        $display("FAIL msb_data: got %h expected 0000a5c3", f.bits >> (NBITS - 16));
      end
      checks++;
      if (f.bits !== e.bits || f.n != e.n || f.low != e.low) begin
        errors++;
        $display("FAIL msb_frame: got %h/%0d/%0d expected %h/%0d/%0d",
                 f.bits, f.n, f.low, e.bits, e.n, e.low);
      end
      checks++;
      if (wd_cnt - base != 1 || word_cnt !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL msb_count: got done=%0d cnt=%0d expected done=1 cnt=%0d",
                 wd_cnt - base, word_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_lsb_div();
    frame_t f, e;
    bit ok;
    msb_first = 1'b0;
    clk_div = 8'd3;
    fifo_q.push_back(16'hA5C3);
    wait_frames(1, 400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lsb_timeout: got no frame expected 1 frame");
    end else begin
      f = got_q.pop_front();
      e = exp_q.pop_front();
      exp_cnt++;
      checks++;
      if ((f.bits >> (NBITS - 16)) !== 32'h0000C3A5 || f.low != NBITS * 8) begin
        errors++;
        $display("FAIL lsb_data: got %h low=%0d expected 0000c3a5 low=%0d",
                 f.bits >> (NBITS - 16), f.low, NBITS * 8);
      end
      checks++;
      if (f.bits !== e.bits || f.n != e.n || word_cnt !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL lsb_frame: got %h/%0d cnt=%0d expected %h/%0d cnt=%0d",
                 f.bits, f.n, word_cnt, e.bits, e.n, exp_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t f, e;
    bit ok;
    msb_first = 1'b1;
    clk_div = 8'd0;
    cap_q.delete();
    repeat (3) fifo_q.push_back(16'($urandom));
    wait_frames(3, 400, ok);
    checks++;
    if (!ok || cap_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_pops: got %0d pops expected 3", cap_q.size());
    end else begin
      checks++;
      if (cap_q[1] - cap_q[0] != 2 * NBITS + 2 || cap_q[2] - cap_q[1] != 2 * NBITS + 2) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d,%0d expected %0d", cap_q[1] - cap_q[0],
                 cap_q[2] - cap_q[1], 2 * NBITS + 2);
      end
      for (int i = 0; i < 3; i++) begin
        f = got_q.pop_front();
        e = exp_q.pop_front();
        exp_cnt++;
        checks++;
        if (f.bits !== e.bits || f.n != e.n || f.low != e.low) begin
          errors++;
          $display("FAIL b2b_frame%0d: got %h/%0d/%0d expected %h/%0d/%0d", i,
                   f.bits, f.n, f.low, e.bits, e.n, e.low);
        end
      end
      checks++;
      if (word_cnt !== 16'(exp_cnt) || bad_rd != 0) begin
        errors++;
        $display("FAIL b2b_count: got cnt=%0d bad_rd=%0d expected cnt=%0d bad_rd=0",
                 word_cnt, bad_rd, exp_cnt);
      end
    end
  endtask

  task automatic test_abort();
    frame_t f, e;
    bit ok = 1'b0;
    int base;
    logic [15:0] w1 = 16'($urandom);
    msb_first = 1'b1;
    clk_div = 8'd1;
    got_q.delete();
    fifo_q.push_back(16'($urandom));
    fifo_q.push_back(w1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (mon_n >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    ser_en = 1'b0;
    base = wd_cnt;
    @(negedge clk);
    checks++;
    if (!ok || {cs_n, sclk, sdo, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_idle: got %b expected 1000", {cs_n, sclk, sdo, busy});
    end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0 || wd_cnt != base || word_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL abort_hold: got rd=%b done=%0d cnt=%0d expected rd=0 done=0 cnt=%0d",
               fifo_rd_en, wd_cnt - base, word_cnt, exp_cnt);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0].n != 5) begin
      errors++;
      $display("FAIL abort_partial: got %0d frames expected 1 frame of 5 bits", got_q.size());
    end
    got_q.delete();
    void'(exp_q.pop_front());
    ser_en = 1'b1;
    wait_frames(1, 300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_resume: got no frame expected 1 frame");
    end else begin
      f = got_q.pop_front();
      e = exp_q.pop_front();
      exp_cnt++;
      checks++;
      if ((f.bits >> (NBITS - 16)) !== {16'h0, w1} || f.bits !== e.bits || f.n != NBITS) begin
        errors++;
        $display("FAIL abort_next_word: got %h/%0d expected %h/%0d", f.bits, f.n, e.bits, NBITS);
      end
    end
  endtask

  task automatic test_random();
    frame_t f, e;
    bit ok;
    int pre;
    got_q.delete();
    for (int it = 0; it < 12; it++) begin
      msb_first  = 1'($urandom);
      clk_div    = 8'($urandom_range(0, 3));
      parity_odd = 1'($urandom);
      pre = cap_q.size();
      fifo_q.push_back(16'($urandom));
      for (int i = 0; i < 50 && cap_q.size() == pre; i++) @(negedge clk);
      repeat ($urandom_range(1, 20)) @(negedge clk);
      // Mid-frame config changes must not disturb the word in flight.
      msb_first  = 1'($urandom);
      clk_div    = 8'($urandom_range(0, 3));
      parity_odd = 1'($urandom);
      wait_frames(1, 600, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin
        errors++;
        $display("FAIL rand%0d_timeout: got no frame expected 1 frame", it);
      end else begin
        f = got_q.pop_front();
        e = exp_q.pop_front();
        exp_cnt++;
        checks++;
        if (f.bits !== e.bits || f.n != e.n || f.low != e.low || word_cnt !== 16'(exp_cnt)) begin
          errors++;
          $display("FAIL rand%0d_frame: got %h/%0d/%0d cnt=%0d expected %h/%0d/%0d cnt=%0d",
                   it, f.bits, f.n, f.low, word_cnt, e.bits, e.n, e.low, exp_cnt);
        end
      end
    end
  endtask

`ifdef FIFO_SER_PARITY_EN
  task automatic test_parity();
    frame_t f;
    bit ok;
    msb_first = 1'b1;
    clk_div = 8'd0;
    for (int p = 0; p < 2; p++) begin
      parity_odd = 1'(p);
      fifo_q.push_back(16'h0001);
      wait_frames(1, 200, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL parity%0d_timeout: got no frame expected 1 frame", p);
      end else begin
        f = got_q.pop_front();
        void'(exp_q.pop_front());
        exp_cnt++;
        checks++;
        if (f.n != 17 || f.bits[0] !== 1'(1 - p)) begin
          errors++;
          $display("FAIL parity%0d_bit: got n=%0d last=%b expected n=17 last=%0d",
                   p, f.n, f.bits[0], 1 - p);
        end
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    bit ok = 1'b0;
    msb_first = 1'b1;
    clk_div = 8'd2;
    fifo_q.push_back(16'($urandom));
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (mon_n >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (!ok || {cs_n, sclk, sdo, busy, word_done, word_cnt} !== {5'b10000, 16'h0}) begin
      errors++;
      $display("FAIL async_reset: got %b_%h expected 10000_0000",
               {cs_n, sclk, sdo, busy, word_done}, word_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    got_q.delete();
    exp_q.delete();
    exp_cnt = 0;
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_msb();
    test_lsb_div();
    test_back_to_back();
    test_abort();
`ifdef FIFO_SER_PARITY_EN
    test_parity();
`endif
    test_random();
    test_async_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (bad_rd != 0) begin
      errors++;
      $display("FAIL illegal_pop: got %0d expected 0", bad_rd);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
